// File: rtl/data_memory_pipe.sv
// data_memory_pipe: handshaked byte-enabled word RAM with a pipelined read path and post-reset clear
module data_memory_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  output logic                    RspValid,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    Busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = READ_LATENCY;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [L-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [L];
  logic acc_rd, acc_wr;
  assign acc_rd   = ReqValid && ReqReady && !ReqWrite && !Reset;
  assign acc_wr   = ReqValid && ReqReady && ReqWrite && !Reset;
  assign RspValid = vld[L-1];
  assign ReadData = dat[L-1];
  always_comb state_n = (state == CLEAR && cnt == '1) ? RUN : state;
  always_ff @(posedge Clock)
    if (Reset) begin
      state    <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt      <= '0;
      ReqReady <= 1'b0;
      Busy     <= CLEAR_ON_RESET != 0;
    end else begin
      state    <= state_n;
      cnt      <= state == CLEAR ? cnt + 1'b1 : cnt;
      ReqReady <= state_n == RUN;
      Busy     <= state_n == CLEAR;
    end
  always_ff @(posedge Clock)
    if (!Reset && state == CLEAR)
      mem[cnt] <= '0;
    else if (acc_wr)
      for (int i = 0; i < NB; i++)
        if (ByteEnable[i]) mem[Address][8*i +: 8] <= WriteData[8*i +: 8];
  // data stages only advance with their valid bit, so the last stage holds between responses
  always_ff @(posedge Clock)
    if (Reset) begin
      vld <= '0;
      for (int i = 0; i < L; i++) dat[i] <= '0;
    end else begin
      vld[0] <= acc_rd;
      if (acc_rd) dat[0] <= mem[Address];
      for (int i = 1; i < L; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: scoreboard bench for a latency-3 clearing instance and a latency-1 non-clearing instance
module tb_data_memory_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1, rst0, v1, v0, wr;
  logic [5:0] addr;
  logic [31:0] wd;
  logic [3:0] be;
  logic rdy1, rsp1, busy1, rdy0, rsp0, busy0;
  logic [31:0] rd1, rd0;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [31:0] d; int due;} exp_t;
  exp_t q1[$], q0[$];
  exp_t e1, e0;
  logic [31:0] m1 [64];
  logic [31:0] m0 [64];
  int n;
  bit bad;

  data_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut1 (
    .Clock(clk), .Reset(rst1), .ReqValid(v1), .ReqReady(rdy1), .ReqWrite(wr), .Address(addr),
    .WriteData(wd), .ByteEnable(be), .RspValid(rsp1), .ReadData(rd1), .Busy(busy1));
  data_memory_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut0 (
    .Clock(clk), .Reset(rst0), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(wr), .Address(addr),
    .WriteData(wd), .ByteEnable(be), .RspValid(rsp0), .ReadData(rd0), .Busy(busy0));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp1) begin
      if (q1.size() == 0) check("rsp1_unexpected", {31'd0, rsp1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rsp1_data", rd1, e1.d);
        check("rsp1_time", cyc, e1.due);
      end
    end
    if (rsp0) begin
      if (q0.size() == 0) check("rsp0_unexpected", {31'd0, rsp0}, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rsp0_data", rd0, e0.d);
        check("rsp0_time", cyc, e0.due);
      end
    end
  end

  task automatic issue(input bit which, input bit w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    wr = w; addr = a; wd = d; be = b;
    if (which) begin
      v1 = 1'b1;
      check("ready1", {31'd0, rdy1}, 32'd1);
      if (!w) begin e.d = m1[a]; e.due = cyc + 3; q1.push_back(e); end
      else for (int i = 0; i < 4; i++) if (b[i]) m1[a][8*i +: 8] = d[8*i +: 8];
    end else begin
      v0 = 1'b1;
      check("ready0", {31'd0, rdy0}, 32'd1);
      if (!w) begin e.d = m0[a]; e.due = cyc + 1; q0.push_back(e); end
      else for (int i = 0; i < 4; i++) if (b[i]) m0[a][8*i +: 8] = d[8*i +: 8];
    end
    @(negedge clk);
    v1 = 1'b0; v0 = 1'b0;
  endtask

  task automatic idle(input int k);
    v1 = 1'b0; v0 = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic count_clear(output int cnt, output bit rr_bad);
    cnt = 0; rr_bad = 1'b0;
    while (busy1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (busy1 && rdy1) rr_bad = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst0 = 1'b1; v1 = 1'b0; v0 = 1'b0; wr = 1'b0; addr = '0; wd = '0; be = '0;
    for (int i = 0; i < 64; i++) begin m1[i] = '0; m0[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_rdy1", {31'd0, rdy1}, 32'd0);
    check("rst_rsp1", {31'd0, rsp1}, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_rdy0", {31'd0, rdy0}, 32'd0);
    check("rst_rd0", rd0, 32'd0);
    rst1 = 1'b0; rst0 = 1'b0;
    count_clear(n, bad);
    check("clear_len", n, 32'd64);
    check("clear_rdy_low", {31'd0, bad}, 32'd0);
    check("rdy1_after_clear", {31'd0, rdy1}, 32'd1);
    check("rdy0_run", {31'd0, rdy0}, 32'd1);
    issue(1, 0, 6'd0, 0, 0);
    issue(1, 0, 6'd31, 0, 0);
    issue(1, 0, 6'd63, 0, 0);
    idle(5);
    issue(1, 1, 6'd5, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 6'd5, 0, 0);
    idle(5);
    check("hold1_data", rd1, 32'hDEADBEEF);
    check("hold1_valid", {31'd0, rsp1}, 32'd0);
    issue(1, 1, 6'd10, 32'h11223344, 4'hF);
    issue(1, 1, 6'd10, 32'hAABBCCDD, 4'b0101);
    issue(1, 0, 6'd10, 0, 0);
    issue(1, 1, 6'd10, 32'hFFFFFFFF, 4'h0);
    issue(1, 0, 6'd10, 0, 0);
    idle(5);
    for (int i = 0; i < 8; i++) issue(1, 1, 6'(i), 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) issue(1, 0, 6'(i), 0, 0);
    idle(6);
    check("q1_drained", q1.size(), 32'd0);
    issue(1, 0, 6'd1, 0, 0);
    issue(1, 0, 6'd2, 0, 0);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    check("midrst_rsp1", {31'd0, rsp1}, 32'd0);
    check("midrst_rd1", rd1, 32'd0);
    check("midrst_busy1", {31'd0, busy1}, 32'd1);
    rst1 = 1'b0;
    repeat (20) @(negedge clk);
    check("clear20_busy1", {31'd0, busy1}, 32'd1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 64; i++) m1[i] = '0;
    count_clear(n, bad);
    check("reclear_len", n, 32'd64);
    check("reclear_rdy_low", {31'd0, bad}, 32'd0);
    issue(1, 0, 6'd5, 0, 0);
    issue(1, 0, 6'd7, 0, 0);
    idle(5);
    check("q1_drained2", q1.size(), 32'd0);
    issue(0, 1, 6'd9, 32'h12345678, 4'hF);
    rst0 = 1'b1;
    @(negedge clk);
    check("rst0_rdy0", {31'd0, rdy0}, 32'd0);
    check("rst0_rsp0", {31'd0, rsp0}, 32'd0);
    rst0 = 1'b0;
    @(negedge clk);
    check("rdy0_first", {31'd0, rdy0}, 32'd1);
    check("busy0_first", {31'd0, busy0}, 32'd0);
    issue(0, 0, 6'd9, 0, 0);
    idle(3);
    check("hold0_data", rd0, 32'h12345678);
    check("hold0_valid", {31'd0, rsp0}, 32'd0);
    check("q0_drained", q0.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
